// File: rtl/ram2_wait_model_pkg.sv
// Shared encodings for the RAM2 wait-state model: control polarities, FSM states
// and the access-type decode used when a MEM request is latched.
package ram2_wait_model_pkg;

    localparam logic RST_ENABLE       = 1'b0;
    localparam logic RAM_CHIP_ENABLE  = 1'b1;
    localparam logic RAM_READ_ENABLE  = 1'b1;
    localparam logic RAM_WRITE_ENABLE = 1'b1;

    localparam logic [1:0] RAM2_ST_IDLE     = 2'b00;
    localparam logic [1:0] RAM2_ST_MEM_BUSY = 2'b01;
    localparam logic [1:0] RAM2_ST_IF_BUSY  = 2'b10;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10
    } ram2_op_e;

    // Write wins over read so a re&we clash still commits the store.
    function automatic ram2_op_e decode_op(input logic re, input logic we);
        if (we == RAM_WRITE_ENABLE) return OP_WRITE;
        if (re == RAM_READ_ENABLE) return OP_READ;
        return OP_NOP;
    endfunction

endpackage

// File: rtl/ram2_wait_model_array.sv
// Synchronous single-port word array with registered read data.
module ram2_array #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 14,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/ram2_wait_model.sv
// RAM2 shared by instruction fetch and MEM: arbitrates the two ports, serialises
// accesses and stretches each one by WAIT_CYCLES to mimic external SRAM timing.
module ram2_wait_model
    import ram2_wait_model_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 1,
    parameter     INIT_FILE   = "",
    parameter int TRACE       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_valid,
    input  logic              mem_ce,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_ack,
    output logic              rw_err,
    output logic              stall_req
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("ram2_wait_model: WAIT_CYCLES must be 0..15");
    end
    if (TRACE != 0 && TRACE != 1) begin : g_bad_trace
        $error("ram2_wait_model: TRACE must be 0 or 1");
    end

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    ram2_op_e          lat_op;

    logic              idle_free;
    logic              accept_mem;
    logic              accept_if;
    logic              busy_done;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_dout;

    // The pulse cycle is spent in IDLE; blocking it stops a held request re-issuing.
    assign idle_free  = (state == RAM2_ST_IDLE) && !mem_ack && !if_valid;
    assign accept_mem = idle_free && (mem_ce == RAM_CHIP_ENABLE);
    assign accept_if  = idle_free && !accept_mem && if_req;
    assign busy_done  = (state != RAM2_ST_IDLE) && (cnt == 4'd0);

    assign arr_we = (rst != RST_ENABLE) && (state == RAM2_ST_MEM_BUSY) &&
                    busy_done && (lat_op == OP_WRITE);

    // Steer the live address while idle so registered dout is ready even with zero waits.
    always_comb begin
        arr_addr = lat_addr;
        if (state == RAM2_ST_IDLE) begin
            arr_addr = (mem_ce == RAM_CHIP_ENABLE) ? mem_addr : if_addr;
        end
    end

    assign stall_req = (rst != RST_ENABLE) &&
                       (((mem_ce == RAM_CHIP_ENABLE) && !mem_ack) || (if_req && !if_valid));

    ram2_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .clk (clk),
        .we  (arr_we),
        .addr(arr_addr),
        .din (lat_data),
        .dout(arr_dout)
    );

    always_ff @(posedge clk) begin
        if (accept_mem) begin
            lat_addr <= mem_addr;
            lat_data <= mem_data_i;
            lat_op   <= decode_op(mem_re, mem_we);
        end else if (accept_if) begin
            lat_addr <= if_addr;
            lat_op   <= OP_READ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state      <= RAM2_ST_IDLE;
            cnt        <= 4'd0;
            if_inst    <= '0;
            mem_data_o <= '0;
            if_valid   <= 1'b0;
            mem_ack    <= 1'b0;
            rw_err     <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            mem_ack  <= 1'b0;
            case (state)
                RAM2_ST_IDLE: begin
                    if (accept_mem) begin
                        state <= RAM2_ST_MEM_BUSY;
                        cnt   <= 4'(WAIT_CYCLES);
                        if (mem_re == RAM_READ_ENABLE && mem_we == RAM_WRITE_ENABLE) begin
                            rw_err <= 1'b1;
                        end
                    end else if (accept_if) begin
                        state <= RAM2_ST_IF_BUSY;
                        cnt   <= 4'(WAIT_CYCLES);
                    end
                end
                RAM2_ST_MEM_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state   <= RAM2_ST_IDLE;
                        mem_ack <= 1'b1;
                        if (lat_op == OP_READ) mem_data_o <= arr_dout;
                    end
                end
                RAM2_ST_IF_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state    <= RAM2_ST_IDLE;
                        if_valid <= 1'b1;
                        if_inst  <= arr_dout;
                    end
                end
                default: state <= RAM2_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram2_wait_model.sv
// Scoreboard bench for ram2_wait_model: drivers queue expected read data, a
// negedge monitor pops and compares on every mem_ack / if_valid pulse.
module tb_ram2_wait_model;

    localparam int DW = 16;
    localparam int AW = 14;
    localparam int WC = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_inst;
    logic          if_valid;
    logic          mem_ce, mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_i, mem_data_o;
    logic          mem_ack, rw_err, stall_req;

    ram2_wait_model #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC), .INIT_FILE(""), .TRACE(0)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst),
        .if_valid(if_valid), .mem_ce(mem_ce), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .mem_ack(mem_ack), .rw_err(rw_err), .stall_req(stall_req)
    );

    // Latency instances for WAIT_CYCLES = 0 and 3.
    logic          l_rst, l_ce0, l_ce3, l_re, l_we, l_zero;
    logic [AW-1:0] l_addr, l_zaddr;
    logic [DW-1:0] l_din;
    logic [DW-1:0] w0_inst, w0_dout, w3_inst, w3_dout;
    logic          w0_ivld, w0_ack, w0_err, w0_stall, w3_ivld, w3_ack, w3_err, w3_stall;

    ram2_wait_model #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(0), .INIT_FILE(""), .TRACE(0)) u_w0 (
        .clk(clk), .rst(l_rst), .if_req(l_zero), .if_addr(l_zaddr), .if_inst(w0_inst),
        .if_valid(w0_ivld), .mem_ce(l_ce0), .mem_re(l_re), .mem_we(l_we),
        .mem_addr(l_addr), .mem_data_i(l_din), .mem_data_o(w0_dout),
        .mem_ack(w0_ack), .rw_err(w0_err), .stall_req(w0_stall)
    );
    ram2_wait_model #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(3), .INIT_FILE(""), .TRACE(0)) u_w3 (
        .clk(clk), .rst(l_rst), .if_req(l_zero), .if_addr(l_zaddr), .if_inst(w3_inst),
        .if_valid(w3_ivld), .mem_ce(l_ce3), .mem_re(l_re), .mem_we(l_we),
        .mem_addr(l_addr), .mem_data_i(l_din), .mem_data_o(w3_dout),
        .mem_ack(w3_ack), .rw_err(w3_err), .stall_req(w3_stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_mem_q [$];
    logic [DW-1:0] exp_if_q  [$];
    logic [DW-1:0] model [int];
    logic [DW-1:0] last_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must be single-cycle and match the head of its queue.
    logic prev_ack = 1'b0;
    logic prev_vld = 1'b0;
    always @(negedge clk) begin
        if (mem_ack === 1'b1) begin
            check("mem_ack_single", {31'd0, prev_ack}, 32'd0);
            if (exp_mem_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mem_ack_unexpected: got ack with data %0h, none queued", mem_data_o);
            end else begin
                check("mem_data_o", {16'd0, mem_data_o}, {16'd0, exp_mem_q.pop_front()});
            end
        end
        if (if_valid === 1'b1) begin
            check("if_valid_single", {31'd0, prev_vld}, 32'd0);
            if (exp_if_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL if_valid_unexpected: got valid with inst %0h, none queued", if_inst);
            end else begin
                check("if_inst", {16'd0, if_inst}, {16'd0, exp_if_q.pop_front()});
            end
        end
        prev_ack = mem_ack;
        prev_vld = if_valid;
    end

    // MEM access on the main DUT; lat = edges from raising mem_ce to seeing mem_ack.
    task automatic mem_op(input logic re, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat);
        @(posedge clk); #1;
        if (we) model[int'(a)] = d;
        else if (re) last_rd = model[int'(a)];
        exp_mem_q.push_back(last_rd);
        mem_ce = 1'b1; mem_re = re; mem_we = we; mem_addr = a; mem_data_i = d;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (mem_ack !== 1'b1 && lat < 40);
        if (mem_ack !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL mem_timeout: got no mem_ack after %0d cycles, required ack", lat);
        end
        mem_ce = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] a, output int lat);
        logic stall_ok;
        @(posedge clk); #1;
        exp_if_q.push_back(model[int'(a)]);
        if_req = 1'b1; if_addr = a;
        #1;
        stall_ok = (stall_req === 1'b1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (if_valid !== 1'b1 && stall_req !== 1'b1) stall_ok = 1'b0;
        end while (if_valid !== 1'b1 && lat < 40);
        check("stall_while_fetch", {31'd0, stall_ok}, 32'd1);
        check("stall_at_valid", {31'd0, stall_req}, 32'd0);
        if_req = 1'b0;
    endtask

    task automatic lat_run(input int sel, input logic we, input logic [DW-1:0] d,
                           output int lat, output logic [DW-1:0] rd);
        @(posedge clk); #1;
        l_we = we; l_re = !we; l_addr = 14'h0042; l_din = d;
        if (sel == 0) l_ce0 = 1'b1; else l_ce3 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (((sel == 0) ? w0_ack : w3_ack) !== 1'b1 && lat < 40);
        rd = (sel == 0) ? w0_dout : w3_dout;
        l_ce0 = 1'b0; l_ce3 = 1'b0;
    endtask

    int            lat_a, lat_b;
    logic [DW-1:0] rd_v;

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = '0; mem_ce = 1'b1; mem_re = 1'b1; mem_we = 1'b0;
        mem_addr = '0; mem_data_i = '0;
        l_rst = 1'b0; l_ce0 = 1'b0; l_ce3 = 1'b0; l_re = 1'b0; l_we = 1'b0; l_zero = 1'b0;
        l_addr = '0; l_zaddr = '0; l_din = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_if_inst", {16'd0, if_inst}, 32'd0);
        check("rst_mem_data_o", {16'd0, mem_data_o}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_mem_ack", {31'd0, mem_ack}, 32'd0);
        check("rst_rw_err", {31'd0, rw_err}, 32'd0);
        check("rst_stall_req", {31'd0, stall_req}, 32'd0);
        if_req = 1'b0; mem_ce = 1'b0; mem_re = 1'b0;
        rst = 1'b1; l_rst = 1'b1;

        // Fetch latency and stall window.
        mem_op(1'b0, 1'b1, 14'h0003, 16'h3120, lat_a);
        check("lat_mem_write", lat_a, WC + 2);
        fetch(14'h0003, lat_a);
        check("lat_fetch", lat_a, WC + 2);

        // Write then read back, and a no-op access.
        mem_op(1'b0, 1'b1, 14'h0100, 16'hBEEF, lat_a);
        mem_op(1'b1, 1'b0, 14'h0100, 16'h0000, lat_a);
        mem_op(1'b0, 1'b0, 14'h0100, 16'h7777, lat_a);
        check("lat_nop", lat_a, WC + 2);

        // Simultaneous IF and MEM: MEM first, IF after the blocked ack edge.
        fork
            mem_op(1'b1, 1'b0, 14'h0003, 16'h0000, lat_a);
            fetch(14'h0100, lat_b);
        join
        check("arb_mem_lat", lat_a, WC + 2);
        check("arb_if_after_mem", lat_b - lat_a, WC + 3);

        // re and we together behave as a write and latch rw_err.
        mem_op(1'b1, 1'b1, 14'h0200, 16'h00AA, lat_a);
        check("rw_err_set", {31'd0, rw_err}, 32'd1);
        mem_op(1'b1, 1'b0, 14'h0200, 16'h0000, lat_a);
        check("rw_err_sticky", {31'd0, rw_err}, 32'd1);

        // Reset mid-write must abandon the store.
        mem_op(1'b0, 1'b1, 14'h0005, 16'h5A5A, lat_a);
        @(posedge clk); #1;
        mem_ce = 1'b1; mem_we = 1'b1; mem_re = 1'b0; mem_addr = 14'h0005; mem_data_i = 16'h1234;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_mem_data_o", {16'd0, mem_data_o}, 32'd0);
        check("midrst_if_inst", {16'd0, if_inst}, 32'd0);
        check("midrst_rw_err", {31'd0, rw_err}, 32'd0);
        check("midrst_stall_req", {31'd0, stall_req}, 32'd0);
        mem_ce = 1'b0; mem_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        last_rd = '0;
        mem_op(1'b1, 1'b0, 14'h0005, 16'h0000, lat_a);

        // Latency versus WAIT_CYCLES, two back-to-back accesses each.
        lat_run(0, 1'b1, 16'hA55A, lat_a, rd_v);
        check("lat_w0_write", lat_a, 2);
        lat_run(0, 1'b0, 16'h0000, lat_a, rd_v);
        check("lat_w0_read", lat_a, 2);
        check("data_w0_read", {16'd0, rd_v}, 32'h0000A55A);
        lat_run(1, 1'b1, 16'hC3C3, lat_a, rd_v);
        check("lat_w3_write", lat_a, 5);
        lat_run(1, 1'b0, 16'h0000, lat_a, rd_v);
        check("lat_w3_read", lat_a, 5);
        check("data_w3_read", {16'd0, rd_v}, 32'h0000C3C3);

        repeat (4) @(posedge clk);
        #1;
        check("mem_queue_drained", exp_mem_q.size(), 0);
        check("if_queue_drained", exp_if_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
